// File: rtl/colour_pkg.sv
// Shared widths, FSM encoding and constants for the colour lookup arbiter.
package colour_pkg;
  localparam int COLOUR_W = 3;
  localparam int RGB_W    = 24;
  localparam logic [RGB_W-1:0] RGB_BLACK = 24'h000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/colour_arbiter_rr_pick2.sv
// Two-way round-robin pick: ptr names the requester favoured when both ask.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic grant,
  output logic valid
);
  assign valid = req0 | req1;
  assign grant = (req0 & req1) ? ptr : req1;
endmodule

// File: rtl/colour_arbiter.sv
// Arbitrates two requesters onto one shared colour->RGB converter of fixed latency.
module colour_arbiter
  import colour_pkg::*;
#(
  parameter int CONV_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic [COLOUR_W-1:0] colour0,
  input  logic [COLOUR_W-1:0] colour1,
  output logic                ack0,
  output logic                ack1,
  output logic [RGB_W-1:0]    rgb_out,
  output logic [COLOUR_W-1:0] conv_colour,
  output logic                conv_enable,
  input  logic [RGB_W-1:0]    conv_rgb,
  output logic                busy
);
  state_t     state, state_nxt;
  logic [2:0] wait_cnt;
  logic       wait_last;
  logic       gidx;
  logic       ptr;
  logic       pick_grant, pick_valid;

  rr_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .ptr   (ptr),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  assign wait_last = (wait_cnt == 3'(CONV_LATENCY - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               wait_cnt <= 3'd0;
    else if (state == WAIT) wait_cnt <= wait_cnt + 3'd1;
    else                    wait_cnt <= 3'd0;
  end

  // Grant index and colour are frozen at arbitration, so later input churn is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gidx        <= 1'b0;
      ptr         <= 1'b0;
      conv_colour <= '0;
      rgb_out     <= RGB_BLACK;
    end else begin
      if (state == IDLE && pick_valid) begin
        gidx        <= pick_grant;
        conv_colour <= pick_grant ? colour1 : colour0;
      end
      if (state == WAIT && wait_last) rgb_out <= conv_rgb;
      if (state == DONE) ptr <= ~gidx;
    end
  end

  assign conv_enable = (state == ISSUE);
  assign busy        = (state != IDLE);
  assign ack0        = (state == DONE) & ~gidx;
  assign ack1        = (state == DONE) & gidx;
endmodule

// File: tb/tb_colour_arbiter.sv
// Drives two arbiters (latency 1 and 3) with identical stimulus and checks them against a timing model.
module tb_colour_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [2:0] colour0 = '0, colour1 = '0;
  logic [1:0] ack0, ack1, conv_enable, busy;
  logic [1:0][23:0] rgb_out, conv_rgb;
  logic [1:0][2:0]  conv_colour;
  logic [6:0][23:0] cp0 = '0, cp1 = '0;

  int compared = 0, mismatched = 0;
  int cyc = 0;

  typedef struct { int cyc; int who; logic [23:0] rgb; } ack_t;
  ack_t aq0[$], aq1[$];

  bit          m_act [2];
  int          m_tg  [2];
  bit          m_gidx[2];
  bit          m_last[2];
  logic [2:0]  m_gcol[2];
  logic [23:0] m_rgb [2];

  always #5 clk = ~clk;

  colour_arbiter #(.CONV_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .colour0(colour0), .colour1(colour1),
    .ack0(ack0[0]), .ack1(ack1[0]), .rgb_out(rgb_out[0]), .conv_colour(conv_colour[0]),
    .conv_enable(conv_enable[0]), .conv_rgb(conv_rgb[0]), .busy(busy[0]));

  colour_arbiter #(.CONV_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .colour0(colour0), .colour1(colour1),
    .ack0(ack0[1]), .ack1(ack1[1]), .rgb_out(rgb_out[1]), .conv_colour(conv_colour[1]),
    .conv_enable(conv_enable[1]), .conv_rgb(conv_rgb[1]), .busy(busy[1]));

  function automatic logic [23:0] lut(input logic [2:0] c);
    case (c)
      3'd1:    return 24'hFF0000;
      3'd2:    return 24'h00FF00;
      3'd5:    return 24'hFF00FF;
      default: return {c, 5'd0, c, 5'd0, c, 5'd0};
    endcase
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Converter models: result appears LATENCY cycles after the enable cycle; junk otherwise.
  always @(posedge clk) begin
    cp0 <= {cp0[5:0], conv_enable[0] ? lut(conv_colour[0]) : 24'hBADBAD};
    cp1 <= {cp1[5:0], conv_enable[1] ? lut(conv_colour[1]) : 24'hBADBAD};
  end
  assign conv_rgb[0] = cp0[0];
  assign conv_rgb[1] = cp1[2];

  task automatic model_reset;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_tg[k] = 0; m_gidx[k] = 0; m_last[k] = 1;
      m_gcol[k] = '0; m_rgb[k] = 24'h0;
    end
  endtask

  task automatic do_reset;
    req0 = 0; req1 = 0; colour0 = '0; colour1 = '0;
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      compared++;
      if ({busy[k], ack0[k], ack1[k], conv_enable[k], conv_colour[k], rgb_out[k]} !== 31'd0) begin
        mismatched++;
        $display("FAIL reset_values[%0d]: busy=%b ack0=%b ack1=%b en=%b ccol=%0d rgb=%h want all zero",
                 k, busy[k], ack0[k], ack1[k], conv_enable[k], conv_colour[k], rgb_out[k]);
      end
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One cycle: apply inputs, compare outputs against the model, then advance the model.
  task automatic step(input logic r0, input logic r1, input logic [2:0] c0, input logic [2:0] c1);
    @(posedge clk);
    #1;
    req0 = r0; req1 = r1; colour0 = c0; colour1 = c1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int   d;
      logic e_done, e_en;
      ack_t a;
      d      = cyc - m_tg[k];
      e_en   = m_act[k] && (d == 1);
      e_done = m_act[k] && (d == 2 + lat(k));
      if (e_done) m_rgb[k] = lut(m_gcol[k]);
      compared++;
      if (busy[k] !== m_act[k]) begin
        mismatched++; $display("FAIL busy[%0d] cyc %0d: got %b want %b", k, cyc, busy[k], m_act[k]);
      end
      compared++;
      if (conv_enable[k] !== e_en) begin
        mismatched++; $display("FAIL conv_enable[%0d] cyc %0d: got %b want %b", k, cyc, conv_enable[k], e_en);
      end
      compared++;
      if (ack0[k] !== (e_done && !m_gidx[k])) begin
        mismatched++; $display("FAIL ack0[%0d] cyc %0d: got %b want %b", k, cyc, ack0[k], e_done && !m_gidx[k]);
      end
      compared++;
      if (ack1[k] !== (e_done && m_gidx[k])) begin
        mismatched++; $display("FAIL ack1[%0d] cyc %0d: got %b want %b", k, cyc, ack1[k], e_done && m_gidx[k]);
      end
      compared++;
      if (rgb_out[k] !== m_rgb[k]) begin
        mismatched++; $display("FAIL rgb_out[%0d] cyc %0d: got %h want %h", k, cyc, rgb_out[k], m_rgb[k]);
      end
      compared++;
      if (conv_colour[k] !== m_gcol[k]) begin
        mismatched++; $display("FAIL conv_colour[%0d] cyc %0d: got %0d want %0d", k, cyc, conv_colour[k], m_gcol[k]);
      end
      if (ack0[k] || ack1[k]) begin
        a.cyc = cyc; a.who = int'(ack1[k]); a.rgb = rgb_out[k];
        if (k == 0) aq0.push_back(a); else aq1.push_back(a);
      end
      if (e_done) begin
        m_act[k] = 0; m_last[k] = m_gidx[k];
      end else if (!m_act[k] && (r0 || r1)) begin
        m_gidx[k] = (r0 && r1) ? !m_last[k] : r1;
        m_gcol[k] = m_gidx[k] ? c1 : c0;
        m_act[k]  = 1;
        m_tg[k]   = cyc;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, 3'd0);
  endtask

  task automatic test_reset;
    do_reset();
    idle(3);
  endtask

  task automatic test_single;
    int t0;
    do_reset(); aq0.delete(); aq1.delete();
    t0 = cyc;
    step(1, 0, 3'd1, 3'd0);
    idle(8);
    compared++;
    if (aq0.size() != 1 || aq0[0].cyc != t0 + 3 || aq0[0].who != 0 || aq0[0].rgb !== 24'hFF0000) begin
      mismatched++;
      $display("FAIL single_lat1: acks=%0d first cyc=%0d who=%0d rgb=%h want 1 ack at %0d who 0 rgb ff0000",
               aq0.size(), aq0.size() ? aq0[0].cyc : -1, aq0.size() ? aq0[0].who : -1,
               aq0.size() ? aq0[0].rgb : 24'h0, t0 + 3);
    end
  endtask

  task automatic test_latency3;
    int t0;
    do_reset(); aq0.delete(); aq1.delete();
    t0 = cyc;
    step(1, 0, 3'd2, 3'd0);
    idle(8);
    compared++;
    if (aq1.size() != 1 || aq1[0].cyc != t0 + 5 || aq1[0].who != 0 || aq1[0].rgb !== 24'h00FF00) begin
      mismatched++;
      $display("FAIL single_lat3: acks=%0d first cyc=%0d who=%0d rgb=%h want 1 ack at %0d who 0 rgb 00ff00",
               aq1.size(), aq1.size() ? aq1[0].cyc : -1, aq1.size() ? aq1[0].who : -1,
               aq1.size() ? aq1[0].rgb : 24'h0, t0 + 5);
    end
  endtask

  task automatic test_contention;
    int t0;
    logic [23:0] want;
    do_reset(); aq0.delete(); aq1.delete();
    t0 = cyc;
    for (int i = 0; i < 17; i++) step(1, 1, 3'd1, 3'd2);
    idle(6);
    compared++;
    if (aq0.size() < 4) begin
      mismatched++; $display("FAIL contention_count: got %0d acks want >= 4", aq0.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        want = (i % 2 == 0) ? 24'hFF0000 : 24'h00FF00;
        compared++;
        if (aq0[i].who != i % 2 || aq0[i].rgb !== want || aq0[i].cyc != t0 + 3 + 4 * i) begin
          mismatched++;
          $display("FAIL contention_ack%0d: cyc=%0d who=%0d rgb=%h want cyc=%0d who=%0d rgb=%h",
                   i, aq0[i].cyc, aq0[i].who, aq0[i].rgb, t0 + 3 + 4 * i, i % 2, want);
        end
      end
    end
  endtask

  task automatic test_stability;
    int t0;
    do_reset(); aq0.delete(); aq1.delete();
    t0 = cyc;
    step(0, 1, 3'd0, 3'd5);
    step(0, 0, 3'd0, 3'd2);
    idle(8);
    compared++;
    if (aq0.size() != 1 || aq0[0].cyc != t0 + 3 || aq0[0].who != 1 || aq0[0].rgb !== 24'hFF00FF) begin
      mismatched++;
      $display("FAIL stability: acks=%0d first cyc=%0d who=%0d rgb=%h want 1 ack at %0d who 1 rgb ff00ff",
               aq0.size(), aq0.size() ? aq0[0].cyc : -1, aq0.size() ? aq0[0].who : -1,
               aq0.size() ? aq0[0].rgb : 24'h0, t0 + 3);
    end
  endtask

  task automatic test_reset_mid;
    do_reset(); aq0.delete(); aq1.delete();
    step(0, 1, 3'd0, 3'd5);
    idle(2);
    do_reset();
    idle(4);
    compared++;
    if (aq0.size() != 0 || aq1.size() != 0) begin
      mismatched++; $display("FAIL reset_mid_noack: got %0d/%0d acks want 0", aq0.size(), aq1.size());
    end
    step(1, 1, 3'd1, 3'd2);
    idle(8);
    compared++;
    if (aq0.size() != 1 || aq0[0].who != 0 || aq1.size() != 1 || aq1[0].who != 0) begin
      mismatched++;
      $display("FAIL reset_mid_rr: acks=%0d/%0d first who=%0d/%0d want one ack each from requester 0",
               aq0.size(), aq1.size(), aq0.size() ? aq0[0].who : -1, aq1.size() ? aq1[0].who : -1);
    end
  endtask

  task automatic test_random;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 80) == 0) do_reset();
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_latency3();
    test_contention();
    test_stability();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
